// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the sram64x22 sequencer/arbiter.
package sram_ctrl_pkg;

  localparam int unsigned AW_DEF = 6;
  localparam int unsigned DW_DEF = 22;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    FLUSH
  } ctrl_state_e;

endpackage

// File: rtl/sram64x22_ctrl_if.sv
// Cache-side request/response bundle of the sram64x22 controller.
interface sram64x22_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  logic          rd_req;
  logic [AW-1:0] rd_idx;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_idx;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          flush_req;
  logic          flush_done;
  logic          busy;

  modport master (
    output rd_req, rd_idx, wr_req, wr_idx, wr_data, flush_req,
    input  rd_gnt, rd_valid, rd_data, wr_gnt, flush_done, busy
  );

  modport slave (
    input  rd_req, rd_idx, wr_req, wr_idx, wr_data, flush_req,
    output rd_gnt, rd_valid, rd_data, wr_gnt, flush_done, busy
  );

endinterface

// File: rtl/arb2_fair.sv
// Two-way read/write arbiter: write has priority, but a read that lost a contested cycle wins
// the next contested cycle.
module arb2_fair (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic rd_req_i,
  input  logic wr_req_i,
  output logic rd_gnt_o,
  output logic wr_gnt_o
);

  logic last_rd_lost_q;
  logic both;

  always_comb begin
    both     = rd_req_i & wr_req_i;
    wr_gnt_o = en_i & wr_req_i & ~(both & last_rd_lost_q);
    rd_gnt_o = en_i & rd_req_i & ~(wr_req_i & ~last_rd_lost_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rd_lost_q <= 1'b0;
    end else begin
      last_rd_lost_q <= both & wr_gnt_o;
    end
  end

endmodule

// File: rtl/sram64x22_ctrl.sv
// Init/flush sweep sequencer and read/write arbiter in front of one single-ported sram64x22.
module sram64x22_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned   AW       = AW_DEF,
  parameter int unsigned   DW       = DW_DEF,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  sram64x22_ctrl_if.slave   bus,
  output logic              sram_cs,
  output logic              sram_we,
  output logic [AW-1:0]     sram_a,
  output logic [DW-1:0]     sram_di,
  input  logic [DW-1:0]     sram_do
);

  ctrl_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rd_valid_q;
  logic          flush_done_q, flush_done_d;
  logic [DW-1:0] hold_q;
  logic          arb_en;
  logic          rd_gnt, wr_gnt;

  // Flush outranks both requesters, so arbitration is suppressed in the cycle it is seen.
  assign arb_en = (state_q == RUN) && !bus.flush_req;

  arb2_fair u_arb (
    .clk      (clk),
    .rst      (rst),
    .en_i     (arb_en),
    .rd_req_i (bus.rd_req),
    .wr_req_i (bus.wr_req),
    .rd_gnt_o (rd_gnt),
    .wr_gnt_o (wr_gnt)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_done_d = 1'b0;
    sram_cs      = 1'b0;
    sram_we      = 1'b0;
    sram_a       = bus.rd_idx;
    sram_di      = bus.wr_data;
    unique case (state_q)
      INIT, FLUSH: begin
        sram_cs = 1'b1;
        sram_we = 1'b1;
        sram_a  = cnt_q;
        sram_di = INIT_VAL;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d      = RUN;
          flush_done_d = (state_q == FLUSH);
        end
      end
      RUN: begin
        if (bus.flush_req) begin
          state_d = FLUSH;
        end else if (wr_gnt) begin
          sram_cs = 1'b1;
          sram_we = 1'b1;
          sram_a  = bus.wr_idx;
        end else if (rd_gnt) begin
          sram_cs = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      rd_valid_q   <= 1'b0;
      flush_done_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_valid_q   <= rd_gnt;
      flush_done_q <= flush_done_d;
      if (rd_valid_q) hold_q <= sram_do;
    end
  end

  // The SRAM output is only trusted while rd_valid is high; otherwise the last read is replayed.
  assign bus.rd_data    = rd_valid_q ? sram_do : hold_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_gnt     = rd_gnt;
  assign bus.wr_gnt     = wr_gnt;
  assign bus.flush_done = flush_done_q;
  assign bus.busy       = (state_q != RUN);

endmodule

// File: tb/tb_sram64x22_ctrl.sv
// Directed and random checks of sram64x22_ctrl against a sweep-count/arbitration reference model.
module tb_sram64x22_ctrl;

  localparam int AW = 6;
  localparam int DW = 22;
  localparam int DEPTH = 64;
  localparam logic [DW-1:0] INIT_VAL = '0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram64x22_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  logic          sram_cs, sram_we;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_di, sram_do;

  sram64x22_ctrl #(.AW(AW), .DW(DW), .INIT_VAL(INIT_VAL)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sram_cs (sram_cs),
    .sram_we (sram_we),
    .sram_a  (sram_a),
    .sram_di (sram_di),
    .sram_do (sram_do)
  );

  // Behavioural single-ported array with registered read data.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) mem[sram_a] <= sram_di;
      else         sram_do <= mem[sram_a];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  int            sweep_left;
  bit            flushing, done_next, rd_lost, pend_v;
  logic [DW-1:0] pend_data, hold;
  logic [DW-1:0] ref_mem [DEPTH];
  bit            e_rg, e_wg;

  // Observed values from the last cycle
  bit            obs_rg, obs_wg, obs_done, obs_valid, obs_swr, obs_busy;
  logic [AW-1:0] obs_a;
  logic [DW-1:0] obs_rdata;

  task automatic model_reset();
    sweep_left = DEPTH;
    flushing   = 0;
    done_next  = 0;
    rd_lost    = 0;
    pend_v     = 0;
    hold       = '0;
  endtask

  task automatic cycle(input bit r, input bit rq, input logic [AW-1:0] ri, input bit wq,
                       input logic [AW-1:0] wi, input logic [DW-1:0] wd, input bit fl);
    bit            e_busy, e_cs, e_we, e_done, e_valid;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_di, e_rdata;
    rst           = r;
    bus.rd_req    = rq;
    bus.rd_idx    = ri;
    bus.wr_req    = wq;
    bus.wr_idx    = wi;
    bus.wr_data   = wd;
    bus.flush_req = fl;
    e_rg = 0; e_wg = 0; e_cs = 0; e_we = 0; e_a = '0; e_di = '0;
    e_valid   = pend_v;
    e_done    = done_next;
    done_next = 0;
    if (pend_v) hold = pend_data;
    e_rdata = hold;
    pend_v  = 0;
    e_busy  = (sweep_left > 0);
    if (e_busy) begin
      e_cs = 1; e_we = 1; e_a = AW'(DEPTH - sweep_left); e_di = INIT_VAL;
      ref_mem[e_a] = INIT_VAL;
      sweep_left--;
      if (sweep_left == 0 && flushing) begin
        done_next = 1;
        flushing  = 0;
      end
    end else if (fl) begin
      sweep_left = DEPTH;
      flushing   = 1;
    end else if (wq && (!rq || !rd_lost)) begin
      e_wg = 1; e_cs = 1; e_we = 1; e_a = wi; e_di = wd;
      ref_mem[wi] = wd;
    end else if (rq) begin
      e_rg = 1; e_cs = 1; e_a = ri;
      pend_v    = 1;
      pend_data = ref_mem[ri];
    end
    rd_lost = rq && wq && e_wg;
    @(negedge clk);
    chk("grants", {bus.wr_gnt, bus.rd_gnt}, {e_wg, e_rg});
    chk("busy", bus.busy, e_busy);
    chk("sram_cs", sram_cs, e_cs);
    if (e_cs) chk("sram_we_a", {sram_we, sram_a}, {e_we, e_a});
    if (e_cs && e_we) chk("sram_di", sram_di, e_di);
    chk("flush_done", bus.flush_done, e_done);
    chk("rd_valid", bus.rd_valid, e_valid);
    chk("rd_data", bus.rd_data, e_rdata);
    obs_rg    = bus.rd_gnt;
    obs_wg    = bus.wr_gnt;
    obs_done  = bus.flush_done;
    obs_valid = bus.rd_valid;
    obs_rdata = bus.rd_data;
    obs_swr   = sram_cs & sram_we;
    obs_a     = sram_a;
    obs_busy  = bus.busy;
    if (r) model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, '0, '0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            first, n_sw, n_done, early;
    bit            done_seen, granted;
    bit            rq_r, wq_r;
    logic [AW-1:0] ri_r, wi_r;
    logic [DW-1:0] wd_r;

    rst = 1'b1;
    bus.rd_req = 0; bus.rd_idx = '0; bus.wr_req = 0; bus.wr_idx = '0;
    bus.wr_data = '0; bus.flush_req = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", {bus.busy, bus.rd_valid, bus.flush_done, sram_cs, sram_we, sram_a},
        {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0});
    chk("reset_rd_data", bus.rd_data, 22'd0);
    @(posedge clk);
    #1;
    model_reset();
    cycle(1, 0, '0, 0, '0, '0, 0);

    // Init sweep: read held from cycle 0 is first granted in cycle 64
    first = -1;
    for (int k = 0; k < 70 && first < 0; k++) begin
      cycle(0, 1, 6'd7, 0, '0, '0, 0);
      if (obs_rg) first = k;
    end
    chk("first_rd_gnt_cycle", first, 64);
    idle(1);
    chk("init_read_value", {obs_valid, obs_rdata}, {1'b1, INIT_VAL});

    // Write then read back the same index
    cycle(0, 0, '0, 1, 6'd5, 22'h2AAAA, 0);
    cycle(0, 1, 6'd5, 0, '0, '0, 0);
    idle(1);
    chk("wr_rd_same_idx", {obs_valid, obs_rdata}, {1'b1, 22'h2AAAA});
    idle(3);
    chk("rd_data_hold", {obs_valid, obs_rdata}, {1'b0, 22'h2AAAA});

    // Contested requests alternate W,R,W,R,W,R
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 6'd20, 1, AW'(30 + i), DW'(22'h100 + i), 0);
      chk("alternation", {obs_wg, obs_rg}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    idle(1);

    // Flush after writes: 64 sweep writes, one done pulse, data invalidated
    for (int i = 10; i <= 12; i++) cycle(0, 0, '0, 1, AW'(i), DW'(22'h1000 + i), 0);
    cycle(0, 0, '0, 0, '0, '0, 1);
    n_sw = 0;
    n_done = 0;
    for (int i = 0; i < 70; i++) begin
      idle(1);
      if (obs_swr) n_sw++;
      if (obs_done) n_done++;
    end
    chk("flush_sweep_writes", n_sw, 64);
    chk("flush_done_pulses", n_done, 1);
    cycle(0, 1, 6'd11, 0, '0, '0, 0);
    idle(1);
    chk("read_after_flush", {obs_valid, obs_rdata}, {1'b1, INIT_VAL});

    // Flush and read in the same cycle: read waits for the sweep
    cycle(0, 0, '0, 1, 6'd20, 22'h3FFFF, 0);
    cycle(0, 1, 6'd20, 0, '0, '0, 1);
    chk("flush_beats_read", obs_rg, 1'b0);
    early = 0;
    done_seen = 0;
    granted = 0;
    for (int i = 0; i < 80 && !granted; i++) begin
      cycle(0, 1, 6'd20, 0, '0, '0, 0);
      if (obs_done) done_seen = 1;
      if (obs_rg) begin
        granted = 1;
        if (!done_seen) early++;
      end
    end
    chk("flush_read_granted", granted, 1'b1);
    chk("flush_no_early_gnt", early, 0);
    idle(1);
    chk("flush_read_value", {obs_valid, obs_rdata}, {1'b1, INIT_VAL});

    // Read right before flush still completes
    cycle(0, 0, '0, 1, 6'd9, 22'h155, 0);
    cycle(0, 1, 6'd9, 0, '0, '0, 0);
    cycle(0, 0, '0, 0, '0, '0, 1);
    chk("read_before_flush", {obs_valid, obs_rdata}, {1'b1, 22'h155});

    // Reset in the middle of the sweep at address 30
    idle(30);
    cycle(1, 0, '0, 0, '0, '0, 0);
    chk("rst_at_sweep_30", obs_a, 6'd30);
    idle(1);
    chk("sweep_restart", {obs_busy, obs_swr, obs_a}, {1'b1, 1'b1, 6'd0});
    idle(63);
    chk("sweep_restart_end", {obs_busy, obs_a}, {1'b1, 6'd63});

    // Reset on a cycle carrying rd_valid
    cycle(0, 0, '0, 1, 6'd9, 22'h2BEEF, 0);
    cycle(0, 1, 6'd9, 0, '0, '0, 0);
    cycle(1, 0, '0, 0, '0, '0, 0);
    chk("rst_on_valid_cycle", obs_valid, 1'b1);
    idle(1);
    chk("rst_drops_valid", {obs_valid, obs_busy, obs_a}, {1'b0, 1'b1, 6'd0});
    idle(63);

    // Random traffic; requests are held until granted
    rq_r = 0; wq_r = 0; ri_r = '0; wi_r = '0; wd_r = '0;
    for (int i = 0; i < 500; i++) begin
      if (!rq_r) begin
        rq_r = ($urandom_range(2) != 0);
        ri_r = AW'($urandom);
      end
      if (!wq_r) begin
        wq_r = ($urandom_range(2) != 0);
        wi_r = AW'($urandom);
        wd_r = DW'($urandom);
      end
      cycle(0, rq_r, ri_r, wq_r, wi_r, wd_r, $urandom_range(59) == 0);
      if (e_rg) rq_r = 0;
      if (e_wg) wq_r = 0;
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
